// File: rtl/knockback_unit.sv
// Per-player percentage tracker and serial shift-add knockback multiplier.
// Optional `PERCENT_CAP_EN saturates the percentage at MAX_PERCENT instead of wrapping.
module knockback_unit #(
    parameter int BASE_KB     = 4,
    parameter int KB_SHIFT    = 3,
    parameter int MAX_PERCENT = 999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] damage,
    input  logic        hit,
    input  logic        respawn,
    output logic [31:0] percent,
    output logic [31:0] knockback,
    output logic        kb_valid,
    output logic        busy,
    output logic        hit_drop
);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pct;
    logic [23:0] mcand;
    logic [7:0]  mplier;
    logic [23:0] product;
    logic [2:0]  count;
    logic [31:0] kb;
    logic        drop_q;

    logic [7:0]  dmg8;
    logic [15:0] pct_new;
    logic [23:0] product_step;
    logic [31:0] kb_new;
    logic        accept;
    logic        drop;

`ifdef PERCENT_CAP_EN
    logic [16:0] pct_sum;
`endif

    always_comb begin
        dmg8 = (damage[31:8] == 24'd0) ? damage[7:0] : 8'hFF;
`ifdef PERCENT_CAP_EN
        pct_sum = {1'b0, pct} + {9'd0, dmg8};
        pct_new = (pct_sum > 17'(MAX_PERCENT)) ? 16'(MAX_PERCENT) : pct_sum[15:0];
`else
        pct_new = pct + {8'd0, dmg8};
`endif
        // Product of the current step; used both for the update and the final result.
        product_step = product + (mplier[0] ? mcand : 24'd0);
        kb_new       = 32'(BASE_KB) + 32'(product_step >> KB_SHIFT);
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drop       = 1'b0;
        if (respawn) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (hit && dmg8 != 8'd0) begin
                        accept     = 1'b1;
                        state_next = MULT;
                    end
                end
                MULT: begin
                    drop = hit;
                    if (count == 3'd7) state_next = DONE;
                end
                DONE: begin
                    drop       = hit;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pct     <= 16'd0;
            mcand   <= 24'd0;
            mplier  <= 8'd0;
            product <= 24'd0;
            count   <= 3'd0;
            kb      <= 32'd0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= drop;
            if (respawn) begin
                pct <= 16'd0;
            end else if (accept) begin
                pct     <= pct_new;
                mcand   <= {8'd0, pct_new};
                mplier  <= dmg8;
                product <= 24'd0;
                count   <= 3'd0;
            end else if (state == MULT) begin
                product <= product_step;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                count   <= count + 3'd1;
                if (count == 3'd7) kb <= kb_new;
            end
        end
    end

    assign percent   = {16'd0, pct};
    assign knockback = kb;
    assign kb_valid  = (state == DONE);
    assign busy      = (state != IDLE);
    assign hit_drop  = drop_q;

endmodule

// File: tb/tb_knockback_unit.sv
// Directed self-checking bench for knockback_unit; expected values are hand-computed.
// Build with +define+PERCENT_CAP_EN to check the saturating variant.
module tb_knockback_unit;

    logic        clock;
    logic        reset;
    logic [31:0] damage;
    logic        hit;
    logic        respawn;
    logic [31:0] percent;
    logic [31:0] knockback;
    logic        kb_valid;
    logic        busy;
    logic        hit_drop;

    int total = 0;
    int bad   = 0;

`ifdef PERCENT_CAP_EN
    localparam logic [31:0] EXP_PCT15 = 32'd999;
    localparam logic [31:0] EXP_KB15  = 32'd1877;
`else
    localparam logic [31:0] EXP_PCT15 = 32'd1005;
    localparam logic [31:0] EXP_KB15  = 32'd1888;
`endif

    knockback_unit dut (
        .clock     (clock),
        .reset     (reset),
        .damage    (damage),
        .hit       (hit),
        .respawn   (respawn),
        .percent   (percent),
        .knockback (knockback),
        .kb_valid  (kb_valid),
        .busy      (busy),
        .hit_drop  (hit_drop)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic h, input logic [31:0] d, input logic r);
        hit     = h;
        damage  = d;
        respawn = r;
        step();
        hit     = 1'b0;
        respawn = 1'b0;
        damage  = 32'd0;
    endtask

    // Full accepted transaction: E0 acceptance, E1-E7 quiet, E8 result, E9 idle
    task automatic runHit(input string tag, input logic [31:0] dmg,
                          input logic [31:0] exp_pct, input logic [31:0] exp_kb);
        int early;
        applyStimulus(1'b1, dmg, 1'b0);
        checkOutput({tag, " pct"}, percent, exp_pct);
        checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
        early = 0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (kb_valid) early++;
        end
        checkOutput({tag, " early"}, early, 32'd0);
        step();
        checkOutput({tag, " valid"}, {31'd0, kb_valid}, 32'd1);
        checkOutput({tag, " kb"}, knockback, exp_kb);
        step();
        checkOutput({tag, " idle"}, {30'd0, busy, kb_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        reset   = 1'b0;
        hit     = 1'b0;
        respawn = 1'b0;
        damage  = 32'd0;
        step();
        step();
        checkOutput("rst pct", percent, 32'd0);
        checkOutput("rst kb", knockback, 32'd0);
        checkOutput("rst flags", {29'd0, kb_valid, busy, hit_drop}, 32'd0);
        reset = 1'b1;
        step();

        runHit("d18", 32'd18, 32'd18, 32'd44);
        runHit("d13", 32'd13, 32'd31, 32'd54);

        // Zero damage in IDLE is ignored entirely
        applyStimulus(1'b1, 32'd0, 1'b0);
        checkOutput("zero busy", {31'd0, busy}, 32'd0);
        checkOutput("zero pct", percent, 32'd31);
        checkOutput("zero drop", {31'd0, hit_drop}, 32'd0);
        step();
        checkOutput("zero valid", {30'd0, kb_valid, hit_drop}, 32'd0);

        // Oversized damage clamps to 255
        runHit("sat300", 32'd300, 32'd286, 32'd9120);
        runHit("sat256", 32'h0000_0100, 32'd541, 32'd17248);
        runHit("satHigh", 32'h8000_0001, 32'd796, 32'd25376);
        runHit("fill", 32'd194, 32'd990, 32'd24011);
        runHit("d15", 32'd15, EXP_PCT15, EXP_KB15);

        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("resp idle pct", percent, 32'd0);
        checkOutput("resp idle kb", knockback, EXP_KB15);

        // Respawn at E4 aborts the multiply
        applyStimulus(1'b1, 32'd50, 1'b0);
        checkOutput("abort pct50", percent, 32'd50);
        step();
        step();
        step();
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("abort pct", percent, 32'd0);
        checkOutput("abort flags", {30'd0, busy, kb_valid}, 32'd0);
        checkOutput("abort kb", knockback, EXP_KB15);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (kb_valid) seen++;
        end
        checkOutput("abort novalid", seen, 32'd0);

        // Hit at E3 is dropped; hit at E9 (DONE) is dropped; hit at E10 accepted
        applyStimulus(1'b1, 32'd18, 1'b0);
        checkOutput("drop pct0", percent, 32'd18);
        step();
        step();
        applyStimulus(1'b1, 32'd7, 1'b0);
        checkOutput("drop E3", {31'd0, hit_drop}, 32'd1);
        checkOutput("drop pct", percent, 32'd18);
        step();
        checkOutput("drop pulse", {31'd0, hit_drop}, 32'd0);
        for (int i = 0; i < 4; i++) step();
        checkOutput("drop valid", {31'd0, kb_valid}, 32'd1);
        checkOutput("drop kb", knockback, 32'd44);
        applyStimulus(1'b1, 32'd5, 1'b0);
        checkOutput("done drop", {31'd0, hit_drop}, 32'd1);
        checkOutput("done busy", {31'd0, busy}, 32'd0);
        checkOutput("done pct", percent, 32'd18);
        runHit("after", 32'd5, 32'd23, 32'd18);

        // Respawn wins over a simultaneous hit, silently
        applyStimulus(1'b1, 32'd9, 1'b1);
        checkOutput("both pct", percent, 32'd0);
        checkOutput("both flags", {30'd0, busy, hit_drop}, 32'd0);

        // Reset mid-multiply clears everything
        applyStimulus(1'b1, 32'd20, 1'b0);
        checkOutput("rst2 pct20", percent, 32'd20);
        step();
        step();
        step();
        reset = 1'b0;
        step();
        checkOutput("rst2 pct", percent, 32'd0);
        checkOutput("rst2 kb", knockback, 32'd0);
        checkOutput("rst2 flags", {29'd0, kb_valid, busy, hit_drop}, 32'd0);
        reset = 1'b1;
        step();
        checkOutput("rst2 idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
